// File: rtl/sdram_page_feeder.sv
// Byte-to-word packer with a two-page ping-pong buffer feeding full-page SDRAM burst writes.
// A page is offered to the controller once complete and streamed one word per window cycle.
module sdram_page_feeder #(
  parameter int PAGE_WORDS = 512,
  parameter int ADDR_W     = 9
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        fifo_tx_rdy,
  input  logic        sdram_rx_rdy,
  output logic [15:0] data,
  output logic [1:0]  pages_held,
  output logic        underrun_err
);

  localparam logic [ADDR_W:0]   PW   = (ADDR_W+1)'(PAGE_WORDS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PAGE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_RELEASE} state_t;
  state_t state_q, state_d;

  logic              rst_done_q;
  logic              phase_q, phase_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic              wr_pg_q, wr_pg_d;
  logic [1:0]        full_q, full_d;
  logic              rd_pg_q, rd_pg_d;
  logic [ADDR_W:0]   rd_idx_q, rd_idx_d;
  logic              zero_q, zero_d;
  logic              over_q, over_d;
  logic              err_q, err_d;
  logic              rd_vld_q, rd_vld_d;
  logic [15:0]       rd_data_q;
  logic [15:0]       mem [2*PAGE_WORDS];

  logic              accept, wr_en, fill;
  logic              start, rd_issue, release_pg;
  logic [ADDR_W:0]   wr_addr, rd_addr;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sdram_rx_rdy)  state_d = S_STREAM;
      S_STREAM:  if (!sdram_rx_rdy) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the IDLE cycle that opens the window already consumes word 0
  always_comb begin
    start       = 1'b0;
    rd_issue    = 1'b0;
    release_pg  = 1'b0;
    fifo_tx_rdy = 1'b0;
    case (state_q)
      S_IDLE: begin
        fifo_tx_rdy = full_q[rd_pg_q];
        start       = sdram_rx_rdy;
        rd_issue    = sdram_rx_rdy;
      end
      S_STREAM:  rd_issue   = sdram_rx_rdy;
      // A window opened on an empty buffer owns no page, so nothing is released
      S_RELEASE: release_pg = !zero_q;
      default: ;
    endcase
  end

  assign in_ready = rst_done_q && !full_q[wr_pg_q];
  assign accept   = in_valid && in_ready;
  assign wr_en    = accept && phase_q;
  assign fill     = wr_en && (wr_idx_q == LAST);
  assign wr_addr  = {wr_pg_q, wr_idx_q};
  assign rd_addr  = {rd_pg_q, start ? {ADDR_W{1'b0}} : rd_idx_q[ADDR_W-1:0]};

  always_comb begin
    phase_d  = accept ? !phase_q : phase_q;
    lo_d     = (accept && !phase_q) ? in_data : lo_q;
    wr_idx_d = wr_en ? wr_idx_q + 1'b1 : wr_idx_q;
    wr_pg_d  = fill ? !wr_pg_q : wr_pg_q;

    full_d = full_q;
    if (release_pg) full_d[rd_pg_q] = 1'b0;
    if (fill)       full_d[wr_pg_q] = 1'b1;
    rd_pg_d = release_pg ? !rd_pg_q : rd_pg_q;

    zero_d = start ? !full_q[rd_pg_q] : zero_q;

    rd_idx_d = rd_idx_q;
    if (start)                          rd_idx_d = (ADDR_W+1)'(1);
    else if (rd_issue && rd_idx_q != PW) rd_idx_d = rd_idx_q + 1'b1;

    over_d   = start ? 1'b0 : (over_q || (rd_issue && rd_idx_q == PW));
    rd_vld_d = rd_issue && !zero_d && (start || rd_idx_q != PW);

    err_d = err_q
         || (start && !full_q[rd_pg_q])
         || (state_q == S_RELEASE && !zero_q && (rd_idx_q != PW || over_q));
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rst_done_q <= 1'b0;
      phase_q    <= 1'b0;
      lo_q       <= '0;
      wr_idx_q   <= '0;
      wr_pg_q    <= 1'b0;
      full_q     <= '0;
      rd_pg_q    <= 1'b0;
      rd_idx_q   <= '0;
      zero_q     <= 1'b0;
      over_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
      phase_q    <= phase_d;
      lo_q       <= lo_d;
      wr_idx_q   <= wr_idx_d;
      wr_pg_q    <= wr_pg_d;
      full_q     <= full_d;
      rd_pg_q    <= rd_pg_d;
      rd_idx_q   <= rd_idx_d;
      zero_q     <= zero_d;
      over_q     <= over_d;
      err_q      <= err_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {in_data, lo_q};
    rd_data_q <= mem[rd_addr];
  end

  assign data         = rd_vld_q ? rd_data_q : '0;
  assign pages_held   = {1'b0, full_q[0]} + {1'b0, full_q[1]};
  assign underrun_err = err_q;

endmodule

// File: tb/tb_sdram_page_feeder.sv
// Directed bench for sdram_page_feeder: page packing, ping-pong back-pressure,
// window length errors and reset behaviour.
module tb_sdram_page_feeder;

  logic        clk;
  logic        n_rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        fifo_tx_rdy;
  logic        sdram_rx_rdy;
  logic [15:0] data;
  logic [1:0]  pages_held;
  logic        underrun_err;

  int checks;
  int failures;

  logic [7:0]  blog [2048];
  logic [15:0] cap  [1024];
  logic [15:0] rel_data;
  logic        ftx_seen, rdy_seen, ready_after, ftx_after;

  sdram_page_feeder #(.PAGE_WORDS(512), .ADDR_W(9)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .fifo_tx_rdy  (fifo_tx_rdy),
    .sdram_rx_rdy (sdram_rx_rdy),
    .data         (data),
    .pages_held   (pages_held),
    .underrun_err (underrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    sdram_rx_rdy = 1'b0;
    step();
    step();
    n_rst = 1'b1;
    step();
    step();
  endtask

  // Push n bytes seed, seed+1, ... and log them at blog[off...]
  task automatic push(input int n, input logic [7:0] seed, input int off);
    for (int i = 0; i < n; i++) begin
      int w;
      in_data  = seed + 8'(i);
      in_valid = 1'b1;
      blog[off+i] = in_data;
      w = 0;
      while (!in_ready && w < 1000) begin
        step();
        w++;
      end
      if (w == 1000) begin
        checks++;
        failures++;
        $display("FAIL push_timeout byte %0d in_ready stayed 0, required 1", i);
        break;
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  // Hold sdram_rx_rdy for n cycles; cap[k] is data in the cycle after the k-th high cycle
  task automatic run_window(input int n);
    ftx_seen = 1'b0;
    rdy_seen = 1'b0;
    sdram_rx_rdy = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      if (k == n - 1) sdram_rx_rdy = 1'b0;
      cap[k] = data;
      if (fifo_tx_rdy) ftx_seen = 1'b1;
      if (in_ready)    rdy_seen = 1'b1;
    end
    step();
    rel_data = data;
    if (fifo_tx_rdy) ftx_seen = 1'b1;
    if (in_ready)    rdy_seen = 1'b1;
    step();
    ready_after = in_ready;
    ftx_after   = fifo_tx_rdy;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; sdram_rx_rdy = 1'b0;
    #1;
    checks++;
    if ({data, fifo_tx_rdy, pages_held, underrun_err, in_ready} !== 21'h0) begin
      failures++;
      $display("FAIL reset_outputs got data=%h ftx=%b ph=%0d err=%b rdy=%b, required all 0",
               data, fifo_tx_rdy, pages_held, underrun_err, in_ready);
    end
    step();
    n_rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_first got %b, required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_then got %b, required 1", in_ready);
    end
  endtask

  task automatic test_single_page();
    int bad; int fk;
    do_reset();
    push(1023, 8'h00, 0);
    checks++;
    if (fifo_tx_rdy !== 1'b0 || pages_held !== 2'd0) begin
      failures++;
      $display("FAIL page1_early got ftx=%b ph=%0d, required 0 0", fifo_tx_rdy, pages_held);
    end
    push(1, 8'hFF, 1023);
    checks++;
    if (fifo_tx_rdy !== 1'b1 || pages_held !== 2'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL page1_full got ftx=%b ph=%0d rdy=%b, required 1 1 1",
               fifo_tx_rdy, pages_held, in_ready);
    end
    run_window(512);
    checks++;
    if (cap[0] !== 16'h0100 || cap[1] !== 16'h0302 || cap[511] !== 16'hFFFE) begin
      failures++;
      $display("FAIL page1_literal got %h %h %h, required 0100 0302 fffe", cap[0], cap[1], cap[511]);
    end
    bad = 0; fk = 0;
    for (int k = 0; k < 512; k++)
      if (cap[k] !== {blog[2*k+1], blog[2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL page1_data word %0d got %h required %h (%0d bad)",
               fk, cap[fk], {blog[2*fk+1], blog[2*fk]}, bad);
    end
    checks++;
    if (pages_held !== 2'd0 || underrun_err !== 1'b0 || ftx_seen !== 1'b0 || rel_data !== 16'h0) begin
      failures++;
      $display("FAIL page1_after got ph=%0d err=%b ftx_in_stream=%b rel_data=%h, required 0 0 0 0000",
               pages_held, underrun_err, ftx_seen, rel_data);
    end
  endtask

  task automatic test_fill_both();
    logic seen;
    do_reset();
    push(2048, 8'h20, 0);
    checks++;
    if (in_ready !== 1'b0 || pages_held !== 2'd2 || fifo_tx_rdy !== 1'b1) begin
      failures++;
      $display("FAIL both_full got rdy=%b ph=%0d ftx=%b, required 0 2 1", in_ready, pages_held, fifo_tx_rdy);
    end
    in_data  = 8'hC3;
    in_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (in_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || pages_held !== 2'd2) begin
      failures++;
      $display("FAIL both_full_hold got rdy_seen=%b ph=%0d, required 0 2", seen, pages_held);
    end
  endtask

  task automatic test_release_refill();
    int bad; int fk;
    run_window(512);
    bad = 0; fk = 0;
    for (int k = 0; k < 512; k++)
      if (cap[k] !== {blog[2*k+1], blog[2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL pageA_data word %0d got %h (%0d bad)", fk, cap[fk], bad);
    end
    checks++;
    if (rdy_seen !== 1'b0 || ready_after !== 1'b1 || ftx_after !== 1'b1) begin
      failures++;
      $display("FAIL release_ready got rdy_in_window=%b rdy_after=%b ftx_after=%b, required 0 1 1",
               rdy_seen, ready_after, ftx_after);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (pages_held !== 2'd1) begin
      failures++;
      $display("FAIL held_byte_taken got ph=%0d, required 1", pages_held);
    end
    run_window(512);
    bad = 0; fk = 0;
    for (int k = 0; k < 512; k++)
      if (cap[k] !== {blog[1024+2*k+1], blog[1024+2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0 || pages_held !== 2'd0 || underrun_err !== 1'b0) begin
      failures++;
      $display("FAIL pageB_data word %0d got %h (%0d bad) ph=%0d err=%b, required 0 bad ph=0 err=0",
               fk, cap[fk], bad, pages_held, underrun_err);
    end
    blog[0] = 8'hC3;
    push(1023, 8'h40, 1);
    run_window(512);
    checks++;
    if (cap[0] !== 16'h40C3 || cap[1] !== 16'h4241 || cap[511] !== {blog[1023], blog[1022]}) begin
      failures++;
      $display("FAIL pageC_held_byte got %h %h %h, required 40c3 4241 %h",
               cap[0], cap[1], cap[511], {blog[1023], blog[1022]});
    end
  endtask

  task automatic test_short_window();
    int bad; int fk;
    do_reset();
    push(2048, 8'h80, 0);
    run_window(300);
    bad = 0; fk = 0;
    for (int k = 0; k < 300; k++)
      if (cap[k] !== {blog[2*k+1], blog[2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL short_data word %0d got %h (%0d bad)", fk, cap[fk], bad);
    end
    checks++;
    if (underrun_err !== 1'b1 || pages_held !== 2'd1 || ftx_after !== 1'b1) begin
      failures++;
      $display("FAIL short_release got err=%b ph=%0d ftx=%b, required 1 1 1",
               underrun_err, pages_held, ftx_after);
    end
    run_window(512);
    bad = 0; fk = 0;
    for (int k = 0; k < 512; k++)
      if (cap[k] !== {blog[1024+2*k+1], blog[1024+2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0 || pages_held !== 2'd0 || underrun_err !== 1'b1) begin
      failures++;
      $display("FAIL short_next_page word %0d got %h (%0d bad) ph=%0d err=%b, required 0 bad ph=0 err=1",
               fk, cap[fk], bad, pages_held, underrun_err);
    end
  endtask

  task automatic test_empty_window();
    int bad;
    do_reset();
    run_window(20);
    bad = 0;
    for (int k = 0; k < 20; k++)
      if (cap[k] !== 16'h0000) bad++;
    checks++;
    if (bad != 0 || rel_data !== 16'h0) begin
      failures++;
      $display("FAIL empty_data got %0d nonzero words rel_data=%h, required 0 0000", bad, rel_data);
    end
    checks++;
    if (underrun_err !== 1'b1 || pages_held !== 2'd0 || ftx_after !== 1'b0) begin
      failures++;
      $display("FAIL empty_flags got err=%b ph=%0d ftx=%b, required 1 0 0",
               underrun_err, pages_held, ftx_after);
    end
  endtask

  task automatic test_reset_mid_stream();
    int bad; int fk;
    do_reset();
    push(1024, 8'h11, 0);
    sdram_rx_rdy = 1'b1;
    for (int k = 0; k < 200; k++) step();
    checks++;
    if (data !== {blog[399], blog[398]}) begin
      failures++;
      $display("FAIL mid_word199 got %h, required %h", data, {blog[399], blog[398]});
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if (data !== 16'h0 || fifo_tx_rdy !== 1'b0 || pages_held !== 2'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got data=%h ftx=%b ph=%0d rdy=%b, required 0000 0 0 0",
               data, fifo_tx_rdy, pages_held, in_ready);
    end
    sdram_rx_rdy = 1'b0;
    step();
    n_rst = 1'b1;
    step();
    step();
    push(1024, 8'h99, 0);
    run_window(512);
    bad = 0; fk = 0;
    for (int k = 0; k < 512; k++)
      if (cap[k] !== {blog[2*k+1], blog[2*k]}) begin
        if (bad == 0) fk = k;
        bad++;
      end
    checks++;
    if (bad != 0 || cap[0] !== 16'h9A99 || underrun_err !== 1'b0 || pages_held !== 2'd0) begin
      failures++;
      $display("FAIL post_reset_page word %0d got %h (%0d bad) w0=%h err=%b ph=%0d, required 0 bad w0=9a99 err=0 ph=0",
               fk, cap[fk], bad, cap[0], underrun_err, pages_held);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_page();
    test_fill_both();
    test_release_refill();
    test_short_window();
    test_empty_window();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
